// File: rtl/tree_route_node.sv
// tree_route_node: 1-to-2 routing node for the tree NoC.
//
// Each incoming flit is steered to port 0 (down/left) or port 1 (up/right)
// according to the address field data[ADDR_LSB +: ADDR_W]. Each port owns
// its own FIFO, so a stalled consumer on one port never blocks flits bound
// for the other port.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where valid && ready are both high. A producer holding valid
// high with ready low keeps its data stable. in_ready depends combinationally
// on in_data, because it reports whether the FIFO for that flit's port has
// room.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data       input flit channel
//   out0_valid/out0_ready/out0_data port 0 (down/left) head of FIFO
//   out1_valid/out1_ready/out1_data port 1 (up/right) head of FIFO
//   sel_valid, sel        one-cycle trace of each routing decision
//   cnt0, cnt1            saturating per-port acceptance counters
//   clr_cnt               synchronous clear of cnt0/cnt1 (wins over increment)
module tree_route_node #(
  parameter int               DATA_W     = 9,
  parameter int               ADDR_W     = 4,
  parameter int               ADDR_LSB   = 5,
  parameter int               LEVEL      = 3,
  parameter int               LEAF       = 0,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b0100,
  parameter int               FIFO_DEPTH = 2,
  parameter int               CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              sel_valid,
  output logic              sel,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  input  logic              clr_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  // LEVEL leading ones in ADDR_W bits (LEVEL 0 gives an all-zero mask).
  localparam logic [ADDR_W-1:0] MASK =
    ~((ADDR_W'(1) << (ADDR_W - LEVEL)) - ADDR_W'(1));

  generate
    if (LEVEL < 0 || LEVEL >= ADDR_W || ADDR_LSB < 0 ||
        ADDR_LSB + ADDR_W > DATA_W || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("tree_route_node: illegal parameter combination");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Route function
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] addr;
  logic              leaf_route;
  logic              level_route;
  logic              route;

  assign addr        = in_data[ADDR_LSB +: ADDR_W];
  assign leaf_route  = ((addr & MASK) != (NODE_ADDR & MASK));
  assign level_route = addr[ADDR_W-1-LEVEL];
  assign route       = (LEAF != 0) ? leaf_route : level_route;

  // ---------------------------------------------------------------------
  // Input acceptance
  // ---------------------------------------------------------------------
  logic [1:0]        full;
  logic [1:0]        not_empty;
  logic [1:0]        ready_v;
  logic [DATA_W-1:0] head [2];
  logic              accept;

  assign ready_v  = {out1_ready, out0_ready};
  // A full FIFO refuses even when it is popped in the same cycle: no bypass.
  assign in_ready = rst_n & ~full[route];
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------
  // Per-port FIFOs
  // ---------------------------------------------------------------------
  generate
    for (genvar k = 0; k < 2; k++) begin : g_port
      localparam logic PORT = (k == 1);

      logic [PTR_W-1:0]  wr_ptr;
      logic [PTR_W-1:0]  rd_ptr;
      logic [OCC_W-1:0]  occ;
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic              push;
      logic              pop;

      assign push         = accept && (route == PORT);
      assign pop          = (occ != '0) && ready_v[k];
      assign full[k]      = (occ == OCC_W'(FIFO_DEPTH));
      assign not_empty[k] = (occ != '0);
      assign head[k]      = mem[rd_ptr];

      // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH for
      // free; occ carries the extra bit that tells full from empty.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
          for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else begin
          if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
          case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
          endcase
        end
      end
    end
  endgenerate

  assign out0_valid = not_empty[0];
  assign out0_data  = head[0];
  assign out1_valid = not_empty[1];
  assign out1_data  = head[1];

  // ---------------------------------------------------------------------
  // Select trace and debug counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid <= 1'b0;
      sel       <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      sel_valid <= accept;
      if (accept) begin
        sel <= route;
      end
      if (clr_cnt) begin
        cnt0 <= '0;
      end else if (accept && !route && cnt0 != '1) begin
        cnt0 <= cnt0 + CNT_W'(1);
      end
      if (clr_cnt) begin
        cnt1 <= '0;
      end else if (accept && route && cnt1 != '1) begin
        cnt1 <= cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tree_route_node.sv
// Testbench for tree_route_node. Two instances: the default configuration
// (internal-level routing, 16-bit counters) and a leaf-mode node with 4-bit
// counters. A negedge scoreboard models the default node with per-port
// queues of flits; scenario tasks add their own targeted checks.
module tb_tree_route_node;

  localparam int DW    = 9;
  localparam int DEPTH = 2;
  localparam int NODE  = 4;  // 4'b0100

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-configuration DUT
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out0_valid, out0_ready, out1_valid, out1_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          sel_valid, sel, clr_cnt;
  logic [15:0]   cnt0, cnt1;

  tree_route_node dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .sel_valid(sel_valid), .sel(sel), .cnt0(cnt0), .cnt1(cnt1),
    .clr_cnt(clr_cnt)
  );

  // Leaf-mode DUT with small counters
  logic          l_in_valid, l_in_ready;
  logic [DW-1:0] l_in_data;
  logic          l_out0_valid, l_out0_ready, l_out1_valid, l_out1_ready;
  logic [DW-1:0] l_out0_data, l_out1_data;
  logic          l_sel_valid, l_sel, l_clr_cnt;
  logic [3:0]    l_cnt0, l_cnt1;

  tree_route_node #(.LEAF(1), .CNT_W(4)) dut_leaf (
    .clk(clk), .rst_n(rst_n),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .out0_valid(l_out0_valid), .out0_ready(l_out0_ready), .out0_data(l_out0_data),
    .out1_valid(l_out1_valid), .out1_ready(l_out1_ready), .out1_data(l_out1_data),
    .sel_valid(l_sel_valid), .sel(l_sel), .cnt0(l_cnt0), .cnt1(l_cnt1),
    .clr_cnt(l_clr_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------
  // Reference routing: address = data bits [8:5] read as a number.
  // Internal level 3 looks at the lowest address bit (odd -> port 1);
  // leaf mode ignores the lowest bit and compares the rest with NODE.
  // ---------------------------------------------------------------------
  function automatic int route_of(input logic [DW-1:0] d, input bit leaf);
    int a;
    a = (int'(d) / 32) % 16;
    if (leaf) return ((a / 2) != (NODE / 2)) ? 1 : 0;
    return a % 2;
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard for the default DUT
  // ---------------------------------------------------------------------
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  int  m_cnt0 = 0, m_cnt1 = 0;
  bit  m_sel_valid = 1'b0, m_sel = 1'b0;
  int  mr;
  bit  m_rdy, m_acc;

  always @(negedge rst_n) begin
    exp0_q.delete();
    exp1_q.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_sel_valid = 1'b0;
    m_sel = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mr    = route_of(in_data, 1'b0);
      m_rdy = ((mr == 1) ? exp1_q.size() : exp0_q.size()) < DEPTH;

      checks++;
      if (in_ready !== m_rdy) begin
        errors++;
        $display("FAIL sb_in_ready: got %b expected %b (data %h)", in_ready, m_rdy, in_data);
      end
      checks++;
      if (out0_valid !== (exp0_q.size() != 0) || out1_valid !== (exp1_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid: got %b%b expected %b%b", out1_valid, out0_valid,
                 exp1_q.size() != 0, exp0_q.size() != 0);
      end
      checks++;
      if (sel_valid !== m_sel_valid || sel !== m_sel) begin
        errors++;
        $display("FAIL sb_sel: got v=%b s=%b expected v=%b s=%b", sel_valid, sel, m_sel_valid, m_sel);
      end
      checks++;
      if (cnt0 !== 16'(m_cnt0) || cnt1 !== 16'(m_cnt1)) begin
        errors++;
        $display("FAIL sb_cnt: got %0d/%0d expected %0d/%0d", cnt0, cnt1, m_cnt0, m_cnt1);
      end

      // Consumption happening at the coming edge
      if (exp0_q.size() != 0 && out0_ready) begin
        checks++;
        if (out0_data !== exp0_q[0]) begin
          errors++;
          $display("FAIL sb_out0_data: got %h expected %h", out0_data, exp0_q[0]);
        end
        void'(exp0_q.pop_front());
      end
      if (exp1_q.size() != 0 && out1_ready) begin
        checks++;
        if (out1_data !== exp1_q[0]) begin
          errors++;
          $display("FAIL sb_out1_data: got %h expected %h", out1_data, exp1_q[0]);
        end
        void'(exp1_q.pop_front());
      end

      // Acceptance happening at the coming edge
      m_acc = in_valid && m_rdy;
      if (m_acc) begin
        if (mr == 1) exp1_q.push_back(in_data);
        else         exp0_q.push_back(in_data);
      end
      m_sel_valid = m_acc;
      if (m_acc) m_sel = (mr == 1);
      if (clr_cnt) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else if (m_acc) begin
        if (mr == 1) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
        else         m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (default DUT). Called at posedge+1, return at posedge+1.
  // ---------------------------------------------------------------------
  task automatic send(input logic [DW-1:0] d, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got %b required 1 for data %h", in_ready, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out valids got %b%b required 00", out1_valid, out0_valid);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 ||
        sel_valid !== 1'b0 || sel !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0 ||
        out0_data !== 9'h000 || out1_data !== 9'h000) begin
      errors++;
      $display("FAIL reset_state: rdy=%b v=%b%b sv=%b s=%b c=%0d/%0d d=%h/%h required all zero",
               in_ready, out1_valid, out0_valid, sel_valid, sel, cnt0, cnt1, out0_data, out1_data);
    end
    checks++;
    if (l_in_ready !== 1'b0 || l_out0_valid !== 1'b0 || l_cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_leaf: rdy=%b v0=%b c0=%0d required 0", l_in_ready, l_out0_valid, l_cnt0);
    end
  endtask

  task automatic test_internal();
    int st;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(9'h000, st);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 9'h000 || sel_valid !== 1'b1 || sel !== 1'b0) begin
      errors++;
      $display("FAIL internal_first: v0=%b d0=%h sv=%b s=%b required 1 000 1 0",
               out0_valid, out0_data, sel_valid, sel);
    end
    send(9'h020, st);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 9'h020 || sel_valid !== 1'b1 || sel !== 1'b1) begin
      errors++;
      $display("FAIL internal_second: v1=%b d1=%h sv=%b s=%b required 1 020 1 1",
               out1_valid, out1_data, sel_valid, sel);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd1 || sel_valid !== 1'b0) begin
      errors++;
      $display("FAIL internal_cnt: cnt0=%0d cnt1=%0d sv=%b required 1 1 0", cnt0, cnt1, sel_valid);
    end
  endtask

  task automatic test_backpressure();
    int st;
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    send(9'h000, st);
    send(9'h040, st);
    in_valid = 1'b1;
    in_data  = 9'h080;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: in_ready got %b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(9'h0E0, st);
    checks++;
    if (st != 0 || out1_valid !== 1'b1 || out1_data !== 9'h0E0) begin
      errors++;
      $display("FAIL bp_other_port: stalls=%0d v1=%b d1=%h required 0 1 0e0", st, out1_valid, out1_data);
    end
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 9'h000) begin
      errors++;
      $display("FAIL bp_hold: v0=%b d0=%h required 1 000", out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    send(9'h080, st);
    wait_drain();
  endtask

  task automatic test_throughput();
    int st, total;
    total = 0;
    out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(9'h020 + 9'(i), st);
      total += st;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL throughput: stall cycles got %0d required 0", total);
    end
    wait_drain();
  endtask

  task automatic test_random();
    bit hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 9'($urandom);
      end
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      clr_cnt    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      hold = in_valid && !in_ready;
      @(posedge clk);
      #1;
    end
    clr_cnt = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int st;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt    = 1'b0;
    out0_ready = 1'b0;
    send(9'h000, st);
    send(9'h040, st);
    checks++;
    if (cnt0 !== 16'd2 || out0_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: cnt0=%0d v0=%b required 2 1", cnt0, out0_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out0_valid !== 1'b0 || cnt0 !== 16'd0 || in_ready !== 1'b0 || out0_data !== 9'h000) begin
      errors++;
      $display("FAIL rst_mid_async: v0=%b cnt0=%0d rdy=%b d0=%h required 0 0 0 000",
               out0_valid, cnt0, in_ready, out0_data);
    end
    #2;
    rst_n      = 1'b1;
    out0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out0_valid !== 1'b0 || cnt0 !== 16'd0) begin
        errors++;
        $display("FAIL rst_mid_stale: v0=%b cnt0=%0d required 0 0", out0_valid, cnt0);
      end
    end
  endtask

  task automatic test_leaf();
    logic [DW-1:0] d;
    int p;
    l_out0_ready = 1'b1;
    l_out1_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      d = 9'h0A0;
      else if (i == 1) d = 9'h0C0;
      else             d = 9'($urandom);
      p = route_of(d, 1'b1);
      l_in_valid = 1'b1;
      l_in_data  = d;
      @(negedge clk);
      checks++;
      if (l_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL leaf_ready: got %b required 1", l_in_ready);
      end
      @(posedge clk);
      #1;
      l_in_valid = 1'b0;
      checks++;
      if (p == 0 && (l_out0_valid !== 1'b1 || l_out0_data !== d || l_out1_valid !== 1'b0)) begin
        errors++;
        $display("FAIL leaf_route: data %h v0=%b d0=%h v1=%b required port 0", d, l_out0_valid, l_out0_data, l_out1_valid);
      end else if (p == 1 && (l_out1_valid !== 1'b1 || l_out1_data !== d || l_out0_valid !== 1'b0)) begin
        errors++;
        $display("FAIL leaf_route: data %h v1=%b d1=%h v0=%b required port 1", d, l_out1_valid, l_out1_data, l_out0_valid);
      end
    end
  endtask

  task automatic test_saturation();
    int stalls;
    stalls    = 0;
    l_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    l_clr_cnt  = 1'b0;
    l_in_valid = 1'b1;
    l_in_data  = 9'h080;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (!l_in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    l_in_valid = 1'b0;
    checks++;
    if (stalls != 0 || l_cnt0 !== 4'd15 || l_cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL sat: stalls=%0d cnt0=%0d cnt1=%0d required 0 15 0", stalls, l_cnt0, l_cnt1);
    end
    l_in_valid = 1'b1;
    l_clr_cnt  = 1'b1;
    @(posedge clk);
    #1;
    l_clr_cnt = 1'b0;
    checks++;
    if (l_cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL clr_priority: cnt0 got %0d required 0", l_cnt0);
    end
    @(posedge clk);
    #1;
    l_in_valid = 1'b0;
    checks++;
    if (l_cnt0 !== 4'd1) begin
      errors++;
      $display("FAIL count_after_clr: cnt0 got %0d required 1", l_cnt0);
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequencer and final report
  // ---------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out0_ready = 1'b0; out1_ready = 1'b0; clr_cnt = 1'b0;
    l_in_valid = 1'b0; l_in_data = '0; l_out0_ready = 1'b0; l_out1_ready = 1'b0; l_clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_internal();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    test_leaf();
    test_saturation();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
